// File: rtl/xnor_popcount_neuron_pkg.sv
// Shared constants for the binary neuron and its pooling neighbour.
// Holds the default geometry, the FSM encoding and a counter width helper.
package xnor_popcount_neuron_pkg;

    localparam int KL_DEF = 9;
    localparam int CW_DEF = 4;
    localparam int PS_DEF = 4;
    localparam int TH_DEF = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        OUT  = ST_OUT
    } state_t;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xnor_popcount_neuron_if.sv
// Bit-pair stream in, thresholded activation strobe out.
// master drives the bit pairs; slave is the neuron.
interface xnor_popcount_neuron_if;

    logic iVALID;
    logic oREADY;
    logic iACT;
    logic iWGT;
    logic oVALID;
    logic oDATA;
    logic oGRP_END;
    logic oBUSY;

    modport master (
        output iVALID, iACT, iWGT,
        input  oREADY, oVALID, oDATA, oGRP_END, oBUSY
    );

    modport slave (
        input  iVALID, iACT, iWGT,
        output oREADY, oVALID, oDATA, oGRP_END, oBUSY
    );

endinterface

// File: rtl/xnor_popcount_neuron_cnt.sv
// Up-counter with synchronous clear and count enable.
// Clear wins over enable; wraps naturally at 2^W.
module xnor_popcount_neuron_cnt #(
    parameter int W = 4
) (
    input  logic         iCLK,
    input  logic         iRSTn,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear first, then increment when enabled.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/xnor_popcount_neuron.sv
// XNOR-popcount binary neuron feeding the OR max-pooling stage.
// Optional runtime threshold register: XNOR_NEURON_THRESH_REG_EN.
module xnor_popcount_neuron
    import xnor_popcount_neuron_pkg::*;
#(
    parameter int KL = KL_DEF,
    parameter int CW = CW_DEF,
    parameter int PS = PS_DEF,
    parameter int TH = TH_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRSTn,
    input  logic                  iCLR,
`ifdef XNOR_NEURON_THRESH_REG_EN
    input  logic                  iTH_LD,
    input  logic [CW-1:0]         iTH,
`endif
    xnor_popcount_neuron_if.slave bus
);

    localparam int TW = cnt_w(KL);
    localparam int GW = cnt_w(PS);

    generate
        if ((2 ** CW) <= KL) begin : g_cw_chk
            $error("CW too narrow for KL");
        end
    endgenerate

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_pop;
    logic          r_data;
    logic [CW-1:0] w_th;
    logic [TW-1:0] w_tap;
    logic [GW-1:0] w_grp;
    logic          w_ready;
    logic          w_out;
    logic          w_xfer;
    logic          w_xnor;
    logic          w_done;
    logic          w_grp_last;
    logic          w_cmp;

`ifdef XNOR_NEURON_THRESH_REG_EN
    logic [CW-1:0] r_th;

    // Runtime threshold; untouched by iCLR.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            r_th <= CW'(TH);
        else if (iTH_LD)
            r_th <= iTH;
    end

    assign w_th = r_th;
`else
    assign w_th = CW'(TH);
`endif

    assign w_out      = (r_state == OUT);
    assign w_ready    = !w_out;
    assign w_xfer     = bus.iVALID & w_ready & ~iCLR;
    assign w_xnor     = bus.iACT ~^ bus.iWGT;
    assign w_done     = w_xfer & (w_tap == TW'(KL - 1));
    assign w_grp_last = (w_grp == GW'(PS - 1));
    assign w_cmp      = (r_pop >= w_th);

    xnor_popcount_neuron_cnt #(.W(TW)) u_tap (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .i_clr (iCLR | w_done),
        .i_en  (w_xfer),
        .o_cnt (w_tap)
    );

    xnor_popcount_neuron_cnt #(.W(GW)) u_grp (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .i_clr (iCLR | (w_out & w_grp_last)),
        .i_en  (w_out),
        .o_cnt (w_grp)
    );

    // State register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end

    // Next state; the unused code falls into the IDLE branch.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ACC: begin
                if (w_done)
                    w_nxt = OUT;
            end
            OUT: begin
                w_nxt = IDLE;
            end
            default: begin
                if (w_done)
                    w_nxt = OUT;
                else if (w_xfer)
                    w_nxt = ACC;
                else
                    w_nxt = IDLE;
            end
        endcase
        if (iCLR)
            w_nxt = IDLE;
    end

    // Popcount: first tap loads, later taps accumulate.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            r_pop <= '0;
        else if (iCLR)
            r_pop <= '0;
        else if (w_xfer) begin
            if (r_state == ACC)
                r_pop <= r_pop + CW'(w_xnor);
            else
                r_pop <= CW'(w_xnor);
        end
    end

    // Holds the last result between strobes.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            r_data <= 1'b0;
        else if (iCLR)
            r_data <= 1'b0;
        else if (w_out)
            r_data <= w_cmp;
    end

    assign bus.oREADY   = w_ready;
    assign bus.oBUSY    = (r_state == ACC);
    assign bus.oVALID   = w_out;
    assign bus.oGRP_END = w_out & w_grp_last;
    assign bus.oDATA    = w_out ? w_cmp : r_data;

endmodule

// File: tb/tb_xnor_popcount_neuron.sv
// Randomised bench for xnor_popcount_neuron against a tap-list model.
// Define XNOR_NEURON_THRESH_REG_EN to also exercise the threshold register.
module tb_xnor_popcount_neuron;
    import xnor_popcount_neuron_pkg::*;

    localparam int KL = KL_DEF;
    localparam int CW = CW_DEF;
    localparam int PS = PS_DEF;
    localparam int TH = TH_DEF;

    logic          iCLK;
    logic          iRSTn;
    logic          iCLR;
    logic          th_ld;
    logic [CW-1:0] th_val;

    xnor_popcount_neuron_if bus ();

    xnor_popcount_neuron #(
        .KL(KL), .CW(CW), .PS(PS), .TH(TH)
    ) dut (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iCLR   (iCLR),
`ifdef XNOR_NEURON_THRESH_REG_EN
        .iTH_LD (th_ld),
        .iTH    (th_val),
`endif
        .bus    (bus)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int n_chk = 0;
    int n_err = 0;

    // Model state: accepted xnor bits of the open kernel, pending result.
    bit m_bits[$];
    bit m_out;
    int m_sum;
    int m_ngrp;
    bit m_gend;
    bit m_data;
    int m_th;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_out  = 0;
        m_sum  = 0;
        m_ngrp = 0;
        m_gend = 0;
        m_data = 0;
        m_th   = TH;
    endtask

    // Drive one cycle, check outputs mid-cycle, advance model on the edge.
    task automatic step(input logic v, input logic a, input logic w,
                        input logic c, input logic tl,
                        input logic [CW-1:0] tv);
        int s;
        bus.iVALID = v;
        bus.iACT   = a;
        bus.iWGT   = w;
        iCLR       = c;
        th_ld      = tl;
        th_val     = tv;
        @(negedge iCLK);
        chk("ready", 32'(bus.oREADY), 32'(!m_out));
        chk("valid", 32'(bus.oVALID), 32'(m_out));
        chk("grp_end", 32'(bus.oGRP_END), 32'(m_out && m_gend));
        chk("busy", 32'(bus.oBUSY), 32'(!m_out && m_bits.size() > 0));
        chk("data", 32'(bus.oDATA),
            32'(m_out ? (m_sum >= m_th) : m_data));
        @(posedge iCLK);
        if (c) begin
            m_bits.delete();
            m_out  = 0;
            m_ngrp = 0;
            m_data = 0;
        end else if (m_out) begin
            m_data = (m_sum >= m_th);
            m_out  = 0;
        end else if (v) begin
            m_bits.push_back(a ~^ w);
            if (m_bits.size() == KL) begin
                s = 0;
                foreach (m_bits[i]) s += m_bits[i];
                m_sum = s;
                m_ngrp++;
                m_gend = (m_ngrp == PS);
                if (m_gend) m_ngrp = 0;
                m_out = 1;
                m_bits.delete();
            end
        end
`ifdef XNOR_NEURON_THRESH_REG_EN
        if (tl) m_th = int'(tv);
`endif
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Present KL taps; mask bit i set means tap i matches.
    task automatic taps(input logic [KL-1:0] mask, input int bub);
        logic a;
        for (int i = 0; i < KL; i++) begin
            while (int'($urandom_range(99)) < bub)
                step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
            a = 1'($urandom);
            step(1'b1, a, mask[i] ? a : ~a, 1'b0, 1'b0, '0);
        end
    endtask

    // Full kernel plus the result cycle, where a stray pair is offered.
    task automatic kernel(input logic [KL-1:0] mask, input int bub,
                          input logic ld, input logic [CW-1:0] tv);
        taps(mask, bub);
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, ld, tv);
    endtask

    task automatic async_rst();
        #1 iRSTn = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.oVALID), 32'd0);
        chk("rst_data", 32'(bus.oDATA), 32'd0);
        chk("rst_grp", 32'(bus.oGRP_END), 32'd0);
        chk("rst_busy", 32'(bus.oBUSY), 32'd0);
        chk("rst_ready", 32'(bus.oREADY), 32'd1);
        model_reset();
        #1 iRSTn = 1'b1;
    endtask

    initial begin
        logic [KL-1:0] all1;
        all1       = '1;
        iRSTn      = 1'b0;
        iCLR       = 1'b0;
        th_ld      = 1'b0;
        th_val     = '0;
        bus.iVALID = 1'b0;
        bus.iACT   = 1'b0;
        bus.iWGT   = 1'b0;
        model_reset();
        #2;
        chk("init_valid", 32'(bus.oVALID), 32'd0);
        chk("init_data", 32'(bus.oDATA), 32'd0);
        chk("init_grp", 32'(bus.oGRP_END), 32'd0);
        chk("init_busy", 32'(bus.oBUSY), 32'd0);
        chk("init_ready", 32'(bus.oREADY), 32'd1);
        @(posedge iCLK);
        #1 iRSTn = 1'b1;

        kernel(9'b000111111, 0, 1'b0, '0);
        idle_step();
        kernel(9'b000001111, 40, 1'b0, '0);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 8; k++)
            kernel(KL'($urandom), 0, 1'b0, '0);
        idle_step();

        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++)
            kernel(all1, 0, 1'b0, '0);

        for (int i = 0; i < 4; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
        async_rst();
        for (int k = 0; k < 4; k++)
            kernel(KL'($urandom), 20, 1'b0, '0);

        taps(9'b011111111, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++)
            kernel(KL'($urandom), 0, 1'b0, '0);

`ifdef XNOR_NEURON_THRESH_REG_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CW'(9));
        kernel(all1, 0, 1'b0, '0);
        kernel(9'b011111111, 0, 1'b0, '0);
        taps(all1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CW'(2));
        kernel(9'b000000111, 0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        kernel(9'b000000011, 0, 1'b0, '0);
        kernel(9'b000000001, 0, 1'b1, CW'(0));
        kernel(9'b000000000, 0, 1'b1, CW'(10));
        kernel(all1, 0, 1'b1, CW'(TH));
`endif

        for (int k = 0; k < 12; k++)
            kernel(KL'($urandom), int'($urandom_range(50)), 1'b0, '0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(99) < 3), 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
